// File: rtl/simon_rev_keysched_if.sv
// Handshake bundle between the Simon key-schedule engine and its round-key consumer.
// The master side starts an expansion and accepts round keys; the slave side is the engine.
interface simon_rev_keysched_if #(
  parameter int N = 48,
  parameter int M = 2
);
  logic           start;
  logic [N*M-1:0] key;
  logic           rkey_ready;
  logic [N-1:0]   rkey;
  logic           rkey_valid;
  logic [6:0]     round_idx;
  logic           busy;
  logic           done;

  modport master (
    output start, key, rkey_ready,
    input  rkey, rkey_valid, round_idx, busy, done
  );

  modport slave (
    input  start, key, rkey_ready,
    output rkey, rkey_valid, round_idx, busy, done
  );
endinterface

// File: rtl/simon_rev_keysched.sv
// Simon key expansion into a local register file, then streamed out last key first.
// Define SIMON_KS_FWD_ORDER_EN to add a dir input selecting ascending output order.
module simon_rev_keysched #(
  parameter int N = 48,
  parameter int M = 2,
  parameter int T = 52
) (
  input  logic clk,
  input  logic rst,
`ifdef SIMON_KS_FWD_ORDER_EN
  input  logic dir,
`endif
  simon_rev_keysched_if.slave bus
);

  localparam int          AW   = (T > 1) ? $clog2(T) : 1;
  localparam logic [6:0]  LAST = 7'(T - 1);
  localparam logic [61:0] Z2   = 62'b10101111011100000011010010011000101000010001111110010110110011;

  typedef enum logic [1:0] {IDLE, EXPAND, OUT} state_t;

  state_t       st;
  logic [6:0]   cnt;
  logic [5:0]   zi;
  logic [N-1:0] rkey_q;
  logic [6:0]   idx_q;
  logic         vld_q;
  logic         busy_q;
  logic         done_q;
  logic         fwd;

  logic [N-1:0] karr [T];

  logic [AW-1:0] a_cur, a_m1, a_m2, a_rd;
  logic [6:0]    next_idx, end_idx;
  logic [N-1:0]  knext, t3, rd_key;

  function automatic logic [N-1:0] ror(input logic [N-1:0] x, input int r);
    return (x >> r) | (x << (N - r));
  endfunction

  // z2 is written leftmost-first, so sequence bit i sits at vector bit 61-i.
  function automatic logic z_bit(input logic [5:0] i);
    return Z2[6'd61 - i];
  endfunction

`ifdef SIMON_KS_FWD_ORDER_EN
  logic dir_q;
  assign fwd = dir_q;
`else
  assign fwd = 1'b0;
`endif

  assign a_cur    = cnt[AW-1:0];
  assign a_m1     = a_cur - AW'(1);
  assign a_m2     = a_cur - AW'(2);
  assign next_idx = fwd ? (idx_q + 7'd1) : (idx_q - 7'd1);
  assign end_idx  = fwd ? LAST : 7'd0;
  assign a_rd     = next_idx[AW-1:0];

  always_comb begin
    t3     = ror(karr[a_m1], 3);
    knext  = ~karr[a_m2] ^ t3 ^ ror(t3, 1) ^ {{(N-2){1'b0}}, 2'b11}
             ^ {{(N-1){1'b0}}, z_bit(zi)};
    rd_key = karr[a_rd];
  end

  // Key storage: loaded on an accepted start, extended one word per EXPAND cycle.
  always_ff @(posedge clk) begin
    if (st == IDLE && bus.start && !done_q) begin
      for (int i = 0; i < M; i++) begin
        karr[i] <= bus.key[i*N +: N];
      end
    end else if (st == EXPAND) begin
      karr[a_cur] <= knext;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st     <= IDLE;
      cnt    <= '0;
      zi     <= '0;
      rkey_q <= '0;
      idx_q  <= '0;
      vld_q  <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
`ifdef SIMON_KS_FWD_ORDER_EN
      dir_q  <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (st)
        IDLE: begin
          // A start coinciding with the done pulse belongs to the finished run.
          if (bus.start && !done_q) begin
            cnt    <= 7'(M);
            zi     <= '0;
            busy_q <= 1'b1;
            st     <= EXPAND;
`ifdef SIMON_KS_FWD_ORDER_EN
            dir_q  <= dir;
`endif
          end
        end
        EXPAND: begin
          cnt <= cnt + 7'd1;
          zi  <= (zi == 6'd61) ? 6'd0 : zi + 6'd1;
          if (cnt == LAST) begin
            st    <= OUT;
            vld_q <= 1'b1;
            if (fwd) begin
              rkey_q <= karr[0];
              idx_q  <= 7'd0;
            end else begin
              // Slot T-1 is being written this cycle, so forward the fresh word.
              rkey_q <= knext;
              idx_q  <= LAST;
            end
          end
        end
        OUT: begin
          if (bus.rkey_ready) begin
            if (idx_q == end_idx) begin
              st     <= IDLE;
              vld_q  <= 1'b0;
              rkey_q <= '0;
              idx_q  <= '0;
              busy_q <= 1'b0;
              done_q <= 1'b1;
            end else begin
              rkey_q <= rd_key;
              idx_q  <= next_idx;
            end
          end
        end
        default: begin
          st     <= IDLE;
          vld_q  <= 1'b0;
          rkey_q <= '0;
          idx_q  <= '0;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.rkey       = rkey_q;
  assign bus.rkey_valid = vld_q;
  assign bus.round_idx  = idx_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;

endmodule
